// File: rtl/cla_chunk_sequencer.sv
// Multi-cycle adder/subtractor: adds two N-bit operands one WIDTH-bit chunk per
// cycle, rippling the carry through a register between chunks.
module cla_chunk_sequencer #(
    parameter int WIDTH  = 8,
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sub,
    input  logic                      clear,
    input  logic [WIDTH*CHUNKS-1:0]   a,
    input  logic [WIDTH*CHUNKS-1:0]   b,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*CHUNKS:0]     sum
);
    localparam int N  = WIDTH * CHUNKS;
    localparam int IW = (CHUNKS < 2) ? 1 : $clog2(CHUNKS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [N-1:0]    op_a, op_b, part;
    logic            cy;
    logic [IW-1:0]   idx;

    logic [N-1:0]    a_sh, b_sh, chunk_mask, part_next;
    logic [WIDTH-1:0] chunk_a, chunk_b;
    logic [WIDTH:0]  chunk_sum;
    logic            idx_ok, idx_last, accept;
    int unsigned     sh;

    // Chunk datapath: select the current chunk, add it, and splice it into the partial result.
    always_comb begin
        sh         = 32'(idx) * WIDTH;
        a_sh       = op_a >> sh;
        b_sh       = op_b >> sh;
        chunk_a    = a_sh[WIDTH-1:0];
        chunk_b    = b_sh[WIDTH-1:0];
        chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{WIDTH{1'b0}}, cy};
        chunk_mask = N'({WIDTH{1'b1}});
        part_next  = (part & ~(chunk_mask << sh)) | (N'(chunk_sum[WIDTH-1:0]) << sh);
        idx_ok     = 32'(idx) < CHUNKS;
        idx_last   = 32'(idx) == CHUNKS - 1;
        accept     = !clear && start && (state == IDLE || state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = RUN;
                RUN: begin
                    if (!idx_ok)       state_next = IDLE;
                    else if (idx_last) state_next = DONE;
                end
                DONE:    state_next = start ? RUN : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
            part <= '0;
            cy   <= 1'b0;
            idx  <= '0;
            sum  <= '0;
        end else if (clear) begin
            cy  <= 1'b0;
            idx <= '0;
        end else if (accept) begin
            op_a <= a;
            op_b <= sub ? ~b : b;
            cy   <= sub;
            idx  <= '0;
        end else if (state == RUN) begin
            if (idx_ok) begin
                part <= part_next;
                cy   <= chunk_sum[WIDTH];
                idx  <= idx_last ? '0 : idx + IW'(1);
                if (idx_last) sum <= {chunk_sum[WIDTH], part_next};
            end else begin
                cy  <= 1'b0;
                idx <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// Directed bench for cla_chunk_sequencer: default 8x4 instance plus an 8x1 instance.
module tb_cla_chunk_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sub, clear;
    logic [31:0] a, b;
    logic        busy, done;
    logic [32:0] sum;
    logic        start1, sub1, clear1;
    logic [7:0]  a1, b1;
    logic        busy1, done1;
    logic [8:0]  sum1;

    int vectors = 0;
    int miscompares = 0;
    int n;
    int ndone;
    logic [32:0] seen_sum;

    always #5 clk = ~clk;

    cla_chunk_sequencer #(.WIDTH(8), .CHUNKS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .clear(clear),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum)
    );

    cla_chunk_sequencer #(.WIDTH(8), .CHUNKS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .clear(clear1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation on the 4-chunk instance, wait (bounded) for done.
    task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                         input logic [32:0] exp, input string tag);
        a = va; b = vb; sub = vs; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_sum"}, 64'(sum), 64'(exp));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; clear = 1'b0; a = '0; b = '0;
        start1 = 1'b0; sub1 = 1'b0; clear1 = 1'b0; a1 = '0; b1 = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum",  64'(sum),  64'd0);
        check("rst_sum1", 64'(sum1), 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // Full carry ripple, cycle by cycle.
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ripple_busy", 64'(busy), 64'd1);
            check("ripple_nodone", 64'(done), 64'd0);
            step();
        end
        check("ripple_done", 64'(done), 64'd1);
        check("ripple_busy_off", 64'(busy), 64'd0);
        check("ripple_sum", 64'(sum), 64'h1_0000_0000);
        step();
        check("ripple_done_1cyc", 64'(done), 64'd0);
        check("ripple_sum_hold", 64'(sum), 64'h1_0000_0000);

        do_op(32'd5, 32'd3, 1'b1, 33'h1_0000_0002, "sub_nb");
        step();
        do_op(32'd3, 32'd5, 1'b1, 33'h0_FFFF_FFFE, "sub_b");
        step();

        // Start during RUN is ignored.
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 32'hDEAD_BEEF; b = 32'h0000_0001; sub = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("ign_sum_hold", 64'(sum), 64'h0_FFFF_FFFE);
        ndone = 0; seen_sum = '0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                ndone++;
                seen_sum = sum;
            end
            step();
        end
        check("ign_ndone", 64'(ndone), 64'd1);
        check("ign_sum", 64'(seen_sum), 64'h0_2345_6789);
        check("ign_idle", 64'(busy), 64'd0);

        // Async reset in the middle of RUN.
        a = 32'h0000_00FF; b = 32'h0000_0001; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_sum",  64'(sum),  64'd0);
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) ndone++;
        end
        check("mid_rst_nodone", 64'(ndone), 64'd0);

        // Clear mid-RUN keeps the previous sum and suppresses done.
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100, "pre_clr");
        step();
        a = 32'h0F0F_0F0F; b = 32'h0101_0101; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_sum", 64'(sum), 64'h0_0000_0100);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            step();
        end
        check("clr_nodone", 64'(ndone), 64'd0);
        clear = 1'b1; start = 1'b1;
        step();
        clear = 1'b0; start = 1'b0;
        check("clr_prio_busy", 64'(busy), 64'd0);

        // Back-to-back: new start in the DONE cycle.
        a = 32'd5; b = 32'd3; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        check("b2b_first_sum", 64'(sum), 64'h0_0000_0008);
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100, "b2b");
        step();

        // Single-chunk instance.
        a1 = 8'hFF; b1 = 8'h01; sub1 = 1'b0; start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("c1_busy", 64'(busy1), 64'd1);
        step();
        check("c1_done", 64'(done1), 64'd1);
        check("c1_sum", 64'(sum1), 64'h100);
        step();
        check("c1_done_off", 64'(done1), 64'd0);
        a1 = 8'h03; b1 = 8'h05; sub1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        check("c1_sub_done", 64'(done1), 64'd1);
        check("c1_sub_sum", 64'(sum1), 64'h0FE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
